// File: rtl/mmio_responder.sv
// Memory-mapped I/O responder for the 0x140-0x147 window: LED register, synchronized
// switches, free-running timer and a mailbox FIFO sharing the tri-stated read bus.
module mmio_responder #(
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  mem_cmd,
    input  logic [8:0]  mem_addr,
    input  logic [15:0] write_data,
    output logic [15:0] read_data,
    input  logic [7:0]  sw,
    output logic [7:0]  leds,
    output logic        fifo_avail
);

    localparam int          PW        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [1:0]  CMD_READ  = 2'b10;
    localparam logic [1:0]  CMD_WRITE = 2'b01;
    localparam logic [3:0]  DEPTH_C   = 4'(FIFO_DEPTH);

    logic [10:0]   prev_r;
    logic [7:0]    leds_r;
    logic [15:0]   timer_r;
    logic [15:0]   fifo_mem_r [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [3:0]    count_r;
    logic          ovf_r;
    logic          udf_r;
    logic [15:0]   hold_r;
    logic          avail_r;
    logic [7:0]    sync_r [SYNC_STAGES];

    logic          is_read_s;
    logic          is_write_s;
    logic          sel_s;
    logic          start_s;
    logic [2:0]    idx_s;
    logic          full_s;
    logic          empty_s;
    logic [15:0]   head_s;
    logic [15:0]   status_s;
    logic [15:0]   rdata_s;
    logic          led_we_s;
    logic          push_s;
    logic          pop_s;
    logic          timer_clr_s;
    logic          w1c_s;

    assign is_read_s   = (mem_cmd == CMD_READ);
    assign is_write_s  = (mem_cmd == CMD_WRITE);
    assign sel_s       = mem_addr[8] & (mem_addr[7:3] == 5'b01000);
    assign idx_s       = mem_addr[2:0];
    // A held command acts once: only the first cycle of a new {cmd, addr} is a start.
    assign start_s     = (is_read_s | is_write_s) & ({mem_cmd, mem_addr} != prev_r);
    assign full_s      = (count_r == DEPTH_C);
    assign empty_s     = (count_r == 4'd0);
    assign head_s      = fifo_mem_r[rd_ptr_r];
    assign status_s    = {8'h00, count_r, udf_r, ovf_r, full_s, empty_s};

    assign led_we_s    = is_write_s & sel_s & (idx_s == 3'd0);
    assign timer_clr_s = start_s & is_write_s & sel_s & (idx_s == 3'd2);
    assign push_s      = start_s & is_write_s & sel_s & (idx_s == 3'd3);
    assign pop_s       = start_s & is_read_s & sel_s & (idx_s == 3'd3);
    assign w1c_s       = start_s & is_write_s & sel_s & (idx_s == 3'd4);

    assign leds        = leds_r;
    assign fifo_avail  = avail_r;
    assign read_data   = (reset_n & is_read_s & sel_s) ? rdata_s : 16'hzzzz;

    // Read mux: the FIFO head is shown on the pop cycle, the hold register afterwards.
    always_comb begin
        rdata_s = 16'h0000;
        case (idx_s)
            3'd0:    rdata_s = {8'h00, leds_r};
            3'd1:    rdata_s = {8'h00, sync_r[SYNC_STAGES-1]};
            3'd2:    rdata_s = timer_r;
            3'd3: begin
                if (start_s) begin
                    rdata_s = empty_s ? 16'h0000 : head_s;
                end else begin
                    rdata_s = hold_r;
                end
            end
            3'd4:    rdata_s = status_s;
            default: rdata_s = 16'h0000;
        endcase
    end

    // Mailbox storage; contents beyond the pointers are don't-care so no reset.
    always_ff @(posedge clk) begin
        if (push_s && !full_s) begin
            fifo_mem_r[wr_ptr_r] <= write_data;
        end
    end

    // Switch synchronizer chain.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_r[i] <= 8'h00;
            end
        end else begin
            sync_r[0] <= sw;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_r[i] <= sync_r[i-1];
            end
        end
    end

    // Control state: access tracking, LEDs, timer, FIFO pointers and sticky flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_r   <= 11'h000;
            leds_r   <= 8'h00;
            timer_r  <= 16'h0000;
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= 4'd0;
            ovf_r    <= 1'b0;
            udf_r    <= 1'b0;
            hold_r   <= 16'h0000;
            avail_r  <= 1'b0;
        end else begin
            prev_r  <= {mem_cmd, mem_addr};
            timer_r <= timer_clr_s ? 16'h0000 : (timer_r + 16'd1);
            if (led_we_s) begin
                leds_r <= write_data[7:0];
            end
            if (push_s) begin
                if (full_s) begin
                    ovf_r <= 1'b1;
                end else begin
                    wr_ptr_r <= wr_ptr_r + PW'(1);
                    count_r  <= count_r + 4'd1;
                    avail_r  <= 1'b1;
                end
            end
            if (pop_s) begin
                if (empty_s) begin
                    udf_r  <= 1'b1;
                    hold_r <= 16'h0000;
                end else begin
                    hold_r   <= head_s;
                    rd_ptr_r <= rd_ptr_r + PW'(1);
                    count_r  <= count_r - 4'd1;
                    avail_r  <= (count_r != 4'd1);
                end
            end
            if (w1c_s) begin
                if (write_data[2]) begin
                    ovf_r <= 1'b0;
                end
                if (write_data[3]) begin
                    udf_r <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_mmio_responder.sv
// Directed and randomized bench for mmio_responder against a queue-based reference model.
module tb_mmio_responder;

    localparam int DEPTH = 4;
    localparam int SS    = 2;
    localparam logic [1:0] RD = 2'b10;
    localparam logic [1:0] WR = 2'b01;
    localparam logic [1:0] NO = 2'b00;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  mem_cmd;
    logic [8:0]  mem_addr;
    logic [15:0] write_data;
    wire  [15:0] read_data;
    logic [7:0]  sw;
    wire  [7:0]  leds;
    wire         fifo_avail;

    int errors = 0;
    int checks = 0;

    mmio_responder #(.FIFO_DEPTH(DEPTH), .SYNC_STAGES(SS)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .mem_cmd    (mem_cmd),
        .mem_addr   (mem_addr),
        .write_data (write_data),
        .read_data  (read_data),
        .sw         (sw),
        .leds       (leds),
        .fifo_avail (fifo_avail)
    );

    always #5 clk = ~clk;

    wire rd_is_z = (read_data === 16'hzzzz);

    // Reference model state
    logic [15:0] q [$];
    logic [7:0]  m_sq [$];
    logic [15:0] m_timer;
    logic [15:0] m_hold;
    logic [7:0]  m_leds;
    logic        m_ovf;
    logic        m_udf;
    logic [1:0]  m_pc;
    logic [8:0]  m_pa;
    logic [15:0] last_rd;
    logic        last_z;
    logic [15:0] v;
    logic [1:0]  r_c;
    logic [8:0]  r_a;
    logic [15:0] r_d;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_z(input string tag, input logic obs_z);
        checks++;
        assert (obs_z === 1'b1) else begin
            errors++;
            $error("FAIL %s: read_data driven as %h, expected z", tag, read_data);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_sq.delete();
        for (int i = 0; i < SS; i++) m_sq.push_back(8'h00);
        m_timer = 16'h0000;
        m_hold  = 16'h0000;
        m_leds  = 8'h00;
        m_ovf   = 1'b0;
        m_udf   = 1'b0;
        m_pc    = 2'b00;
        m_pa    = 9'h000;
    endtask

    // One bus cycle: drive at negedge, check mid-cycle, advance model at posedge.
    task automatic step(input logic [1:0] c, input logic [8:0] a, input logic [15:0] d);
        logic rd, wr, sel, start, full, empty;
        logic [2:0]  idx;
        logic [15:0] exp;
        logic [7:0]  s_now;
        mem_cmd = c; mem_addr = a; write_data = d;
        #2;
        rd    = (c == RD);
        wr    = (c == WR);
        sel   = a[8] && (a[7:3] == 5'b01000);
        idx   = a[2:0];
        start = (rd || wr) && ({c, a} != {m_pc, m_pa});
        full  = (q.size() == DEPTH);
        empty = (q.size() == 0);
        case (idx)
            3'd0:    exp = {8'h00, m_leds};
            3'd1:    exp = {8'h00, m_sq[0]};
            3'd2:    exp = m_timer;
            3'd3:    exp = start ? (empty ? 16'h0000 : q[0]) : m_hold;
            3'd4:    exp = {8'h00, 4'(q.size()), m_udf, m_ovf, full, empty};
            default: exp = 16'h0000;
        endcase
        last_rd = read_data;
        last_z  = rd_is_z;
        if (rd && sel) begin
            checks++;
            assert (!rd_is_z && read_data === exp) else begin
                errors++;
                $error("FAIL rdata addr %h: observed %h expected %h", a, read_data, exp);
            end
        end else begin
            chk_z("rdata_float", rd_is_z);
        end
        chk("leds", {8'h00, leds}, {8'h00, m_leds});
        chk("fifo_avail", {15'h0000, fifo_avail}, {15'h0000, !empty});
        s_now = sw;
        @(posedge clk);
        m_timer = (start && wr && sel && idx == 3'd2) ? 16'h0000 : m_timer + 16'd1;
        if (wr && sel && idx == 3'd0) m_leds = d[7:0];
        if (start && wr && sel && idx == 3'd3) begin
            if (full) m_ovf = 1'b1;
            else q.push_back(d);
        end
        if (start && rd && sel && idx == 3'd3) begin
            if (empty) begin
                m_udf  = 1'b1;
                m_hold = 16'h0000;
            end else begin
                m_hold = q.pop_front();
            end
        end
        if (start && wr && sel && idx == 3'd4) begin
            if (d[2]) m_ovf = 1'b0;
            if (d[3]) m_udf = 1'b0;
        end
        m_sq.push_back(s_now);
        m_sq.delete(0);
        m_pc = c;
        m_pa = a;
        @(negedge clk);
    endtask

    task automatic push(input logic [15:0] d);
        step(WR, 9'h143, d);
        step(NO, 9'h000, 16'h0000);
    endtask

    task automatic pop(output logic [15:0] val);
        step(RD, 9'h143, 16'h0000);
        val = last_rd;
        step(NO, 9'h000, 16'h0000);
    endtask

    initial begin
        reset_n = 1'b0; mem_cmd = NO; mem_addr = 9'h000; write_data = 16'h0000; sw = 8'h00;
        model_reset();
        #2;
        chk_z("reset_float", rd_is_z);
        chk("reset_leds", {8'h00, leds}, 16'h0000);
        chk("reset_avail", {15'h0000, fifo_avail}, 16'h0000);
        mem_cmd = RD; mem_addr = 9'h140;
        #1;
        chk_z("reset_read_float", rd_is_z);
        mem_cmd = NO; mem_addr = 9'h000;
        @(negedge clk);
        reset_n = 1'b1;

        // LED register
        repeat (3) step(WR, 9'h140, 16'h00A5);
        chk("leds_a5", {8'h00, leds}, 16'h00A5);
        step(RD, 9'h140, 16'h0000);
        chk("led_read", last_rd, 16'h00A5);
        step(RD, 9'h040, 16'h0000);
        chk_z("ram_half_float", last_z);

        // FIFO fill, overflow and W1C
        push(16'h1111); push(16'h2222); push(16'h3333); push(16'h4444); push(16'h5555);
        step(RD, 9'h144, 16'h0000);
        chk("status_ovf", last_rd, 16'h0046);
        step(WR, 9'h144, 16'h0004);
        step(RD, 9'h144, 16'h0000);
        chk("status_w1c", last_rd, 16'h0042);
        step(NO, 9'h000, 16'h0000);

        // Held pop acts once and stays stable
        for (int i = 0; i < 3; i++) begin
            step(RD, 9'h143, 16'h0000);
            chk("held_pop", last_rd, 16'h1111);
        end
        step(NO, 9'h000, 16'h0000);
        step(RD, 9'h144, 16'h0000);
        chk("status_after_held", last_rd, 16'h0030);
        pop(v); chk("pop_2222", v, 16'h2222);
        pop(v); chk("pop_3333", v, 16'h3333);
        pop(v); chk("pop_4444", v, 16'h4444);
        push(16'h1111); push(16'h2222); push(16'h3333); push(16'h4444);
        pop(v); chk("pop_a", v, 16'h1111);
        pop(v); chk("pop_b", v, 16'h2222);
        pop(v); chk("pop_c", v, 16'h3333);
        pop(v); chk("pop_d", v, 16'h4444);
        pop(v); chk("pop_empty", v, 16'h0000);
        step(RD, 9'h144, 16'h0000);
        chk("status_udf", last_rd, 16'h0009);

        // Timer
        step(WR, 9'h142, 16'h0000);
        repeat (10) step(NO, 9'h000, 16'h0000);
        step(RD, 9'h142, 16'h0000);
        chk("timer_10", last_rd, 16'h000A);
        step(WR, 9'h142, 16'h1234);
        step(RD, 9'h142, 16'h0000);
        chk("timer_clear", last_rd, 16'h0000);
        step(WR, 9'h142, 16'h0000);
        repeat (65536) step(NO, 9'h000, 16'h0000);
        step(RD, 9'h142, 16'h0000);
        chk("timer_wrap", last_rd, 16'h0000);

        // Switch synchronizer latency
        sw = 8'h3C;
        for (int i = 0; i < SS; i++) begin
            step(RD, 9'h141, 16'h0000);
            chk("sw_old", last_rd, 16'h0000);
        end
        step(RD, 9'h141, 16'h0000);
        chk("sw_new", last_rd, 16'h003C);

        // Reset in the middle of a held push
        step(WR, 9'h143, 16'h7777);
        step(WR, 9'h143, 16'h7777);
        reset_n = 1'b0;
        model_reset();
        #2;
        chk_z("midreset_float", rd_is_z);
        chk("midreset_leds", {8'h00, leds}, 16'h0000);
        chk("midreset_avail", {15'h0000, fifo_avail}, 16'h0000);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) step(WR, 9'h143, 16'h7777);
        step(NO, 9'h000, 16'h0000);
        step(RD, 9'h144, 16'h0000);
        chk("status_after_reset", last_rd, 16'h0010);

        // Randomized traffic, including held commands and out-of-window addresses
        r_c = NO; r_a = 9'h000; r_d = 16'h0000;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 9) < 7) begin
                r_c = 2'($urandom_range(0, 3));
                r_a = ($urandom_range(0, 9) == 0) ? 9'($urandom) : (9'h140 + 9'($urandom_range(0, 7)));
                r_d = 16'($urandom);
            end
            if ($urandom_range(0, 19) == 0) sw = 8'($urandom);
            step(r_c, r_a, r_d);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
